// File: rtl/prng_arb_pkg.sv
// Shared types and pure helpers for the shared xorshift32 PRNG arbiter.
package prng_arb_pkg;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_SERVE  = 1'b1
    } fsm_e;

    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;
    localparam int unsigned WCNT_W       = 8;

    // One xorshift32 step with shifts 13/17/5.
    function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Zero is the xorshift fixed point, so it is never allowed as a seed.
    function automatic logic [31:0] fix_seed(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic [IW-1:0] idx_o
);

    localparam int unsigned SW = IW + 1;

    logic [SW-1:0] sum;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        win_o = '0;
        idx_o = '0;
        sum   = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = {1'b0, ptr_i} + SW'(i);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            cand = sum[IW-1:0];
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                idx_o       = cand;
                win_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prng_share_arbiter.sv
// One xorshift32 generator shared round-robin among NUM_REQ requesters,
// with seed load and a warm-up phase that discards the first WARMUP steps.
module prng_share_arbiter
    import prng_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter logic [31:0] SEED    = DEFAULT_SEED,
    parameter int unsigned WARMUP  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [31:0]        rand_out_o,
    input  logic               seed_load_i,
    input  logic [31:0]        seed_data_i,
    output logic               ready_o
);

    localparam int unsigned       PTR_W     = $clog2(NUM_REQ);
    localparam logic [31:0]       SEED_FIX  = fix_seed(SEED);
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WARMUP);

    fsm_e               fsm_q, fsm_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [31:0]        x_q, x_d;
    logic [31:0]        rand_q, rand_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               ready_q, ready_d;
    logic [NUM_REQ-1:0] win;
    logic [PTR_W-1:0]   win_idx;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (PTR_W)
    ) u_rr (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .win_o (win),
        .idx_o (win_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q   <= ST_WARMUP;
            wcnt_q  <= WCNT_INIT;
            x_q     <= SEED_FIX;
            rand_q  <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            wcnt_q  <= wcnt_d;
            x_q     <= x_d;
            rand_q  <= rand_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
        end
    end

    // Seed load overrides everything; grants only come out of SERVE.
    always_comb begin
        fsm_d  = fsm_q;
        wcnt_d = wcnt_q;
        x_d    = x_q;
        rand_d = rand_q;
        gnt_d  = '0;
        ptr_d  = ptr_q;
        if (seed_load_i) begin
            x_d    = fix_seed(seed_data_i);
            wcnt_d = WCNT_INIT;
            fsm_d  = ST_WARMUP;
        end else begin
            case (fsm_q)
                ST_WARMUP: begin
                    if (wcnt_q == '0) begin
                        fsm_d = ST_SERVE;
                    end else begin
                        x_d    = xorshift32_step(x_q);
                        wcnt_d = wcnt_q - WCNT_W'(1);
                    end
                end
                ST_SERVE: begin
                    if (|req_i) begin
                        gnt_d  = win;
                        x_d    = xorshift32_step(x_q);
                        rand_d = x_d;
                        ptr_d  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                  : win_idx + PTR_W'(1);
                    end
                end
                default: fsm_d = ST_WARMUP;
            endcase
        end
        ready_d = (fsm_d == ST_SERVE);
    end

    assign gnt_o      = gnt_q;
    assign rand_out_o = rand_q;
    assign ready_o    = ready_q;

`ifdef FORMAL
    logic [7:0] starve_q [NUM_REQ];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) starve_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_i[i] || gnt_d[i]) starve_q[i] <= '0;
                else if (|gnt_d)           starve_q[i] <= starve_q[i] + 8'd1;
            end
        end
    end

    always_comb begin
        assert (x_q != 32'h0);
        assert ($onehot0(gnt_q));
        for (int i = 0; i < NUM_REQ; i++) assert (starve_q[i] < 8'(NUM_REQ));
    end

    assert property (@(posedge clock) disable iff (reset)
        (|gnt_d) |-> (ready_q && |(gnt_d & req_i)));
`endif

endmodule
